// File: rtl/red_pitaya_pfd_unwrap.sv
// Unwraps the per-cycle wrapped phase word into a saturating multi-turn phase and
// produces a windowed frequency estimate (sum of phase steps over 2^FREQ_LOG2 samples).
module red_pitaya_pfd_unwrap #(
    parameter int PHASEWIDTH = 10,
    parameter int TURNWIDTH  = 4,
    parameter int SIGNALBITS = TURNWIDTH + PHASEWIDTH,
    parameter int FREQ_LOG2  = 10,
    parameter int SETTLE     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PHASEWIDTH-1:0] phase_i,
    input  logic                  phase_valid_i,
    input  logic                  clear_i,
    output logic [SIGNALBITS-1:0] integral_o,
    output logic [SIGNALBITS-1:0] freq_o,
    output logic                  freq_valid_o,
    output logic [1:0]            sat_o
);

    localparam int SUMBITS = SIGNALBITS + FREQ_LOG2;
    localparam int SCW     = $clog2(SETTLE + 2);

    localparam logic signed [SIGNALBITS-1:0] S_MAX = {1'b0, {(SIGNALBITS-1){1'b1}}};
    localparam logic signed [SIGNALBITS-1:0] S_MIN = {1'b1, {(SIGNALBITS-1){1'b0}}};
    localparam logic [SCW-1:0]       SETTLE_ONE = {{(SCW-1){1'b0}}, 1'b1};
    localparam logic [SCW-1:0]       SETTLE_END = SCW'(SETTLE);
    localparam logic [FREQ_LOG2-1:0] WIN_ONE    = {{(FREQ_LOG2-1){1'b0}}, 1'b1};
    localparam logic [FREQ_LOG2-1:0] WIN_LAST   = {FREQ_LOG2{1'b1}};

    typedef enum logic [1:0] {
        FLUSH   = 2'd0,
        TRACK   = 2'd1,
        SAT_POS = 2'd2,
        SAT_NEG = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic signed [SIGNALBITS-1:0]  acc_q, acc_d;
    logic [PHASEWIDTH-1:0]         last_q, last_d;
    logic [SCW-1:0]                settle_q;
    logic [FREQ_LOG2-1:0]          win_cnt_q;
    logic signed [SUMBITS-1:0]     win_sum_q;
    logic signed [SIGNALBITS-1:0]  freq_q;
    logic                          freq_vld_q;

    logic signed [PHASEWIDTH-1:0]  step;
    logic signed [SIGNALBITS:0]    step_ext;
    logic signed [SIGNALBITS-1:0]  step_s;
    logic signed [SIGNALBITS:0]    acc_n;
    logic signed [SUMBITS-1:0]     sum_n;
    logic [SUMBITS-SIGNALBITS:0]   sum_top;
    logic signed [SIGNALBITS-1:0]  sum_sat;

    // Modular difference; a step of exactly half a turn reads as the negative half turn.
    assign step     = phase_i - last_q;
    assign step_ext = {{(SIGNALBITS+1-PHASEWIDTH){step[PHASEWIDTH-1]}}, step};
    assign step_s   = step_ext[SIGNALBITS-1:0];
    assign acc_n    = {acc_q[SIGNALBITS-1], acc_q} + step_ext;

    // Window sum uses the raw step so the estimate keeps running while the integral is clamped.
    assign sum_n   = win_sum_q + {{(SUMBITS-PHASEWIDTH){step[PHASEWIDTH-1]}}, step};
    assign sum_top = sum_n[SUMBITS-1:SIGNALBITS-1];

    always_comb begin
        sum_sat = sum_n[SIGNALBITS-1:0];
        if (!((&sum_top) || (~|sum_top))) begin
            sum_sat = sum_n[SUMBITS-1] ? S_MIN : S_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        last_d  = phase_i;
        unique case (state_q)
            FLUSH: begin
                last_d = last_q;
                if (settle_q == SETTLE_END) begin
                    last_d  = phase_i;
                    acc_d   = SIGNALBITS'(phase_i);
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (acc_n[SIGNALBITS:SIGNALBITS-1] == 2'b01) begin
                    acc_d   = S_MAX;
                    state_d = SAT_POS;
                end else if (acc_n[SIGNALBITS:SIGNALBITS-1] == 2'b10) begin
                    acc_d   = S_MIN;
                    state_d = SAT_NEG;
                end else begin
                    acc_d = acc_n[SIGNALBITS-1:0];
                end
            end
            SAT_POS: begin
                if (step < 0) begin
                    acc_d   = S_MAX + step_s;
                    state_d = TRACK;
                end
            end
            SAT_NEG: begin
                if (step > 0) begin
                    acc_d   = S_MIN + step_s;
                    state_d = TRACK;
                end
            end
            default: begin
                state_d = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        freq_vld_q <= 1'b0;
        if (rst_i || clear_i) begin
            state_q   <= FLUSH;
            acc_q     <= '0;
            last_q    <= '0;
            settle_q  <= '0;
            win_cnt_q <= '0;
            win_sum_q <= '0;
            freq_q    <= '0;
        end else if (phase_valid_i) begin
            state_q <= state_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            if (state_q == FLUSH) begin
                if (settle_q != SETTLE_END) begin
                    settle_q <= settle_q + SETTLE_ONE;
                end
            end else begin
                win_cnt_q <= win_cnt_q + WIN_ONE;
                if (win_cnt_q == WIN_LAST) begin
                    freq_q     <= sum_sat;
                    freq_vld_q <= 1'b1;
                    win_sum_q  <= '0;
                end else begin
                    win_sum_q <= sum_n;
                end
            end
        end
    end

    assign integral_o   = acc_q;
    assign freq_o       = freq_q;
    assign freq_valid_o = freq_vld_q;
    assign sat_o        = {state_q == SAT_NEG, state_q == SAT_POS};

endmodule

// File: tb/tb_red_pitaya_pfd_unwrap.sv
// Randomized and directed bench for red_pitaya_pfd_unwrap against an integer reference model.
module tb_red_pitaya_pfd_unwrap;

    localparam int PW     = 10;
    localparam int SB     = 14;
    localparam int FL2    = 4;
    localparam int SETTLE = 8;
    localparam int SMAX   = 8191;
    localparam int SMIN   = -8192;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [PW-1:0] phase_i = '0;
    logic          phase_valid_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [SB-1:0] integral_o;
    logic [SB-1:0] freq_o;
    logic          freq_valid_o;
    logic [1:0]    sat_o;

    red_pitaya_pfd_unwrap #(
        .PHASEWIDTH(PW), .TURNWIDTH(4), .SIGNALBITS(SB), .FREQ_LOG2(FL2), .SETTLE(SETTLE)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .phase_i(phase_i), .phase_valid_i(phase_valid_i),
        .clear_i(clear_i), .integral_o(integral_o), .freq_o(freq_o),
        .freq_valid_o(freq_valid_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: counts of samples, integer phase, clamp mode, queue of window steps.
    int m_seen;
    bit m_track;
    int m_acc, m_last, m_freq, m_sat;
    bit m_fv;
    int win_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int wrap_step(input int ph, input int last);
        int d;
        d = ((ph - last) % 1024 + 1024) % 1024;
        if (d >= 512) d -= 1024;
        return d;
    endfunction

    task automatic model(input bit rst, input bit clr, input bit v, input int ph);
        int d, n, s;
        m_fv = 0;
        if (rst || clr) begin
            m_seen = 0; m_track = 0; m_acc = 0; m_last = 0; m_freq = 0; m_sat = 0;
            win_q.delete();
        end else if (v) begin
            if (!m_track) begin
                m_seen++;
                if (m_seen == SETTLE + 1) begin
                    m_track = 1; m_last = ph; m_acc = ph;
                end
            end else begin
                d = wrap_step(ph, m_last);
                m_last = ph;
                if (m_sat == 1) begin
                    if (d < 0) begin m_acc = SMAX + d; m_sat = 0; end
                end else if (m_sat == -1) begin
                    if (d > 0) begin m_acc = SMIN + d; m_sat = 0; end
                end else begin
                    n = m_acc + d;
                    if (n > SMAX) begin m_acc = SMAX; m_sat = 1; end
                    else if (n < SMIN) begin m_acc = SMIN; m_sat = -1; end
                    else m_acc = n;
                end
                win_q.push_back(d);
                if (win_q.size() == (1 << FL2)) begin
                    s = 0;
                    foreach (win_q[i]) s += win_q[i];
                    m_freq = (s > SMAX) ? SMAX : ((s < SMIN) ? SMIN : s);
                    m_fv = 1;
                    win_q.delete();
                end
            end
        end
    endtask

    int cur_ph = 0;

    task automatic step(input bit rst, input bit clr, input bit v, input int ph);
        @(negedge clk);
        rst_i = rst; clear_i = clr; phase_valid_i = v; phase_i = PW'(ph);
        if (v && !rst && !clr) cur_ph = ph & 1023;
        @(posedge clk);
        model(rst, clr, v, ph & 1023);
        #1;
        check("integral", $signed(integral_o), m_acc);
        check("sat", int'(sat_o), (m_sat == -1) ? 2 : ((m_sat == 1) ? 1 : 0));
        check("freq_valid", int'(freq_valid_o), int'(m_fv));
        check("freq", $signed(freq_o), m_freq);
    endtask

    task automatic advance(input int d);
        step(0, 0, 1, (cur_ph + d) & 1023);
    endtask

    int prev, dlt, drift;
    int pulses;

    initial begin
        // Reset
        step(1, 0, 0, 0);
        step(1, 0, 1, 77);
        check("rst_integral", $signed(integral_o), 0);
        check("rst_sat", int'(sat_o), 0);
        check("rst_fv", int'(freq_valid_o), 0);

        // Settle: 8 samples ignored, 9th captured
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        check("t1_flush", $signed(integral_o), 0);
        step(0, 0, 1, 100);
        check("t1_capture", $signed(integral_o), 100);
        check("t1_sat", int'(sat_o), 0);

        // Ramp through the phase wrap
        for (int i = 0; i < 20; i++) begin
            prev = $signed(integral_o);
            advance(64);
            check("t2_mono", $signed(integral_o) - prev, 64);
        end

        // Ramp into positive clamp, then back out
        for (int i = 0; i < 40; i++) advance(256);
        check("t3_clamp", $signed(integral_o), SMAX);
        check("t3_sat", int'(sat_o), 1);
        advance(-256);
        check("t3_unclamp", $signed(integral_o), 7935);
        check("t3_unsat", int'(sat_o), 0);

        // Clear with a valid sample mid-ramp
        step(0, 1, 1, cur_ph + 64);
        check("t6_int", $signed(integral_o), 0);
        check("t6_freq", $signed(freq_o), 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, $urandom_range(0, 1023));
        check("t6_ignored", $signed(integral_o), 0);
        step(0, 0, 1, 0);
        check("t6_resume", $signed(integral_o), 0);

        // Constant +3 with gaps: window of 16 sums to 48
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 2) == 0) step(0, 0, 0, $urandom_range(0, 1023));
            else advance(3);
            if (freq_valid_o) begin
                pulses++;
                check("t4_freq", $signed(freq_o), 48);
            end
        end
        check("t4_pulse_seen", int'(pulses > 0), 1);

        // Exactly half a turn reads as negative
        prev = $signed(integral_o);
        advance(512);
        check("t5_half", $signed(integral_o), prev - 512);

        // Randomized drift with gaps, occasional clears and half-turn steps
        for (int i = 0; i < 3000; i++) begin
            drift = ((i / 400) % 2 == 0) ? 180 : -180;
            dlt = drift + int'($urandom_range(0, 600)) - 300;
            if ($urandom_range(0, 99) == 0) dlt = 512;
            if ($urandom_range(0, 399) == 0)
                step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1023));
            else if ($urandom_range(0, 3) == 0)
                step(0, 0, 0, $urandom_range(0, 1023));
            else
                advance(dlt);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
